// File: rtl/mux_lane_scanner_if.sv
// Result stream from the lane scanner: one {lane, value} entry per transfer.
// Latency: n/a (wires only).
// Backpressure: the master holds an entry while out_valid & !out_ready.
//
// Signals
//   out_valid  master -> slave  head entry is valid
//   out_ready  slave  -> master consumer accepts the head this edge
//   out_lane   master -> slave  lane index of the head entry
//   out_data   master -> slave  sampled mux value of the head entry
interface mux_lane_scanner_if #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2
);

  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  out_lane;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    input  out_ready,
    output out_lane,
    output out_data
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_lane,
    input  out_data
  );

endinterface

// File: rtl/mux_lane_scanner.sv
// Sweeps the lane mux select, samples each lane and queues non-zero values.
// Latency: lane sampled on edge N is at the FIFO head from cycle N+1 (empty FIFO).
// Backpressure: a full FIFO stalls the sweep on the current lane; nothing is dropped.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start_i        pulse, begins a sweep from lane 0 (IDLE only)
//   cont_i         1: wrap to lane 0 after the last lane, 0: stop after one sweep
//   abort_i        return to IDLE on the next edge, queued entries are kept
//   sel_o          registered mux select, never above NUM_LANES-1
//   mux_out_i      mux output, combinational response to sel_o
//   busy_o         high in SCAN or STALL
//   sweep_done_o   one-cycle pulse after the last lane's sample completes
//   out_if         {lane, value} result stream (valid/ready)
module mux_lane_scanner #(
  parameter int NUM_LANES = 31,
  parameter int SEL_W     = 5,
  parameter int DATA_W    = 2,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   cont_i,
  input  logic                   abort_i,
  output logic [SEL_W-1:0]       sel_o,
  input  logic [DATA_W-1:0]      mux_out_i,
  output logic                   busy_o,
  output logic                   sweep_done_o,
  mux_lane_scanner_if.master     out_if
);

  // Pointers and count carry one extra bit so full and empty are distinct.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  lane;
    logic [DATA_W-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             done_q,  done_d;

  entry_t           mem_q [DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  logic   fifo_vld;
  logic   pop;
  logic   push;
  logic   push_ok;
  logic   sample_nz;
  logic   at_last;
  entry_t head;
  entry_t wr_entry;

  assign fifo_vld  = (count_q != '0);
  assign pop       = fifo_vld & out_if.out_ready;
  // A pop on the same edge frees the slot the push needs, so full+pop still pushes.
  assign push_ok   = (count_q < DEPTH_C) | pop;
  assign sample_nz = |mux_out_i;
  assign at_last   = (sel_q == LAST_LANE);

  assign wr_entry.lane = sel_q;
  assign wr_entry.data = mux_out_i;

  // ---------------------------------------------------------------------------
  // Sweep control: next state, select, push, done
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    push    = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start_i) begin
          state_d = SCAN;
        end
      end

      // STALL evaluates the lane exactly like SCAN; it only differs in that
      // the lane is being retried after a full-FIFO refusal.
      SCAN, STALL: begin
        if (sample_nz && !push_ok) begin
          state_d = STALL;
        end else begin
          push = sample_nz;
          if (at_last) begin
            done_d  = 1'b1;
            sel_d   = '0;
            state_d = cont_i ? SCAN : IDLE;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = SCAN;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    // Abort wins over start, over a pending push and over the done pulse.
    if (abort_i) begin
      state_d = IDLE;
      sel_d   = '0;
      done_d  = 1'b0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are masked by fifo_vld below.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Head fields are forced to zero while empty so reset values hold immediately.
  assign out_if.out_valid = fifo_vld;
  assign out_if.out_lane  = fifo_vld ? head.lane : '0;
  assign out_if.out_data  = fifo_vld ? head.data : '0;

  assign sel_o        = sel_q;
  assign busy_o       = (state_q != IDLE);
  assign sweep_done_o = done_q;

endmodule

// File: tb/tb_mux_lane_scanner.sv
module tb_mux_lane_scanner;

  localparam int SEL_W  = 5;
  localparam int DATA_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              cont_i;
  logic              abort_i;
  logic [SEL_W-1:0]  sel_o;
  logic [DATA_W-1:0] mux_out_i;
  logic              busy_o;
  logic              sweep_done_o;

  mux_lane_scanner_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) out_if ();

  mux_lane_scanner #(
    .NUM_LANES(31),
    .SEL_W    (SEL_W),
    .DATA_W   (DATA_W),
    .DEPTH    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .cont_i      (cont_i),
    .abort_i     (abort_i),
    .sel_o       (sel_o),
    .mux_out_i   (mux_out_i),
    .busy_o      (busy_o),
    .sweep_done_o(sweep_done_o),
    .out_if      (out_if)
  );

  always #5 clk = ~clk;

  // Behavioural 32:1 lane mux; select 31 reads the default zero.
  logic [DATA_W-1:0] lane_val [0:31];
  assign mux_out_i = lane_val[sel_o];

  int vectors     = 0;
  int miscompares = 0;
  logic [SEL_W+DATA_W-1:0] got [$];
  int done_cnt;
  int done_at [$];
  int vld_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [DATA_W-1:0] v);
    for (int i = 0; i < 32; i++) lane_val[i] = v;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Pop with ready held high until idle and empty; records every popped entry.
  task automatic drain(input int budget);
    out_if.out_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (out_if.out_valid) got.push_back({out_if.out_lane, out_if.out_data});
      step();
      if (!busy_o && !out_if.out_valid) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    cont_i = 1'b0;
    abort_i = 1'b0;
    out_if.out_ready = 1'b0;
    set_all(2'b00);
    lane_val[31] = 2'b00;

    // ---------------- reset state ----------------
    #1;
    check("rst_sel",   32'(sel_o), 32'd0);
    check("rst_valid", 32'(out_if.out_valid), 32'd0);
    check("rst_lane",  32'(out_if.out_lane), 32'd0);
    check("rst_data",  32'(out_if.out_data), 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_done",  32'(sweep_done_o), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // ---------------- test 1: single sweep, lanes 3 and 17 ----------------
    lane_val[3]  = 2'b01;
    lane_val[17] = 2'b11;
    out_if.out_ready = 1'b1;
    got.delete();
    done_cnt = 0;
    pulse_start();
    check("t1_busy_start", 32'(busy_o), 32'd1);
    check("t1_sel_start",  32'(sel_o), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      step();
      if (out_if.out_valid) got.push_back({out_if.out_lane, out_if.out_data});
      if (sweep_done_o) done_cnt++;
      if (i == 30) check("t1_busy_e30", 32'(busy_o), 32'd1);
      if (i == 31) begin
        check("t1_busy_e31", 32'(busy_o), 32'd0);
        check("t1_done_e31", 32'(sweep_done_o), 32'd1);
        check("t1_sel_e31",  32'(sel_o), 32'd0);
      end
    end
    step();
    if (sweep_done_o) done_cnt++;
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_n_entries", 32'(got.size()), 32'd2);
    check("t1_entry0", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'h0D);
    check("t1_entry1", (got.size() > 1) ? 32'(got[1]) : 32'hFFFF, 32'h47);

    // ---------------- test 2: all lanes 10, stall on full ----------------
    set_all(2'b10);
    out_if.out_ready = 1'b0;
    got.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) step();
    check("t2_stall_sel",  32'(sel_o), 32'd4);
    check("t2_stall_busy", 32'(busy_o), 32'd1);
    check("t2_head_valid", 32'(out_if.out_valid), 32'd1);
    check("t2_head_lane",  32'(out_if.out_lane), 32'd0);
    check("t2_head_data",  32'(out_if.out_data), 32'd2);
    drain(200);
    check("t2_drained", 32'(busy_o | out_if.out_valid), 32'd0);
    check("t2_n_entries", 32'(got.size()), 32'd31);
    for (int i = 0; i < 31; i++) begin
      logic [SEL_W-1:0] ln;
      ln = i[SEL_W-1:0];
      check($sformatf("t2_entry%0d", i),
            (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'({ln, 2'b10}));
    end

    // ---------------- test 6: full + pop + non-zero sample ----------------
    set_all(2'b01);
    out_if.out_ready = 1'b0;
    got.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    check("t6_sel_full", 32'(sel_o), 32'd4);
    out_if.out_ready = 1'b1;
    step();
    check("t6_no_stall_sel", 32'(sel_o), 32'd5);
    check("t6_busy",         32'(busy_o), 32'd1);
    check("t6_head_lane",    32'(out_if.out_lane), 32'd1);
    out_if.out_ready = 1'b0;
    step();
    check("t6_still_full_sel", 32'(sel_o), 32'd5);
    step();
    check("t6_stall_hold_sel", 32'(sel_o), 32'd5);
    drain(200);
    check("t6_n_entries", 32'(got.size()), 32'd30);
    check("t6_first", (got.size() > 0)  ? 32'(got[0])  : 32'hFFFF, 32'h05);
    check("t6_last",  (got.size() > 29) ? 32'(got[29]) : 32'hFFFF, 32'h79);

    // ---------------- test 3: continuous, all zero ----------------
    set_all(2'b00);
    cont_i = 1'b1;
    out_if.out_ready = 1'b1;
    done_at.delete();
    vld_seen = 0;
    pulse_start();
    for (int i = 1; i <= 70; i++) begin
      step();
      if (sweep_done_o) done_at.push_back(i);
      if (out_if.out_valid) vld_seen++;
      if (i == 30) check("t3_sel_e30", 32'(sel_o), 32'd30);
      if (i == 31) begin
        check("t3_sel_wrap",  32'(sel_o), 32'd0);
        check("t3_busy_wrap", 32'(busy_o), 32'd1);
      end
    end
    check("t3_done_cnt", 32'(done_at.size()), 32'd2);
    check("t3_done_1st", (done_at.size() > 0) ? 32'(done_at[0]) : 32'hFFFF, 32'd31);
    check("t3_done_2nd", (done_at.size() > 1) ? 32'(done_at[1]) : 32'hFFFF, 32'd62);
    check("t3_no_valid", 32'(vld_seen), 32'd0);
    cont_i = 1'b0;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("t3_abort_busy", 32'(busy_o), 32'd0);
    check("t3_abort_sel",  32'(sel_o), 32'd0);
    check("t3_abort_done", 32'(sweep_done_o), 32'd0);

    // ---------------- test 4: abort at lane 10 with two queued ----------------
    lane_val[2] = 2'b11;
    lane_val[5] = 2'b01;
    out_if.out_ready = 1'b0;
    got.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) step();
    check("t4_sel_pre", 32'(sel_o), 32'd10);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("t4_busy",      32'(busy_o), 32'd0);
    check("t4_sel",       32'(sel_o), 32'd0);
    check("t4_head_lane", 32'(out_if.out_lane), 32'd2);
    check("t4_head_data", 32'(out_if.out_data), 32'd3);
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("t4_abort_over_start", 32'(busy_o), 32'd0);
    drain(10);
    check("t4_n_entries", 32'(got.size()), 32'd2);
    check("t4_entry0", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'h0B);
    check("t4_entry1", (got.size() > 1) ? 32'(got[1]) : 32'hFFFF, 32'h15);
    check("t4_idle_after", 32'(busy_o), 32'd0);

    // ---------------- test 5: async reset mid-STALL ----------------
    set_all(2'b11);
    out_if.out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) step();
    check("t5_stall_sel", 32'(sel_o), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_if.out_valid), 32'd0);
    check("t5_rst_sel",   32'(sel_o), 32'd0);
    check("t5_rst_busy",  32'(busy_o), 32'd0);
    check("t5_rst_lane",  32'(out_if.out_lane), 32'd0);
    step();
    #2;
    rst = 1'b0;
    step();
    pulse_start();
    check("t5_restart_sel",   32'(sel_o), 32'd0);
    check("t5_restart_busy",  32'(busy_o), 32'd1);
    check("t5_restart_valid", 32'(out_if.out_valid), 32'd0);
    step();
    check("t5_sel_1",  32'(sel_o), 32'd1);
    check("t5_lane_0", 32'(out_if.out_lane), 32'd0);
    check("t5_data_0", 32'(out_if.out_data), 32'd3);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
